general_register_file: RTL

//  Parametrised general-purpose register file for the CPU datapath.

---
 rtl/general_register_file_if.sv | 27 ++
 rtl/general_register_file.sv | 98 +++++++++
 2 files changed

// File: rtl/general_register_file_if.sv
// Control-unit / datapath bundle for general_register_file: selectors, write op and data in;
// registered read data, flags and selector-error pulse out.
interface general_register_file_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 3
);
    logic [SEL_WIDTH-1:0]  src_a_sel;
    logic [SEL_WIDTH-1:0]  src_b_sel;
    logic [SEL_WIDTH-1:0]  dest_sel;
    logic [2:0]            wr_op;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  zero_flag;
    logic                  carry_flag;
    logic                  sel_err;

    modport master (
        output src_a_sel, src_b_sel, dest_sel, wr_op, wr_data,
        input  src_a, src_b, zero_flag, carry_flag, sel_err
    );

    modport slave (
        input  src_a_sel, src_b_sel, dest_sel, wr_op, wr_data,
        output src_a, src_b, zero_flag, carry_flag, sel_err
    );
endinterface

// File: rtl/general_register_file.sv
// Parametrised register file: two registered read ports, op-coded write port, zero/carry flags.
// Define REGFILE_BYPASS_EN to forward a same-edge write result to a matching read port.
module general_register_file #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    REG_COUNT   = 8,
    parameter int                    SEL_WIDTH   = 3,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input logic                    clk,
    input logic                    reset,
    general_register_file_if.slave bus
);
    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_INC  = 3'd2,
        OP_DEC  = 3'd3,
        OP_CLR  = 3'd4
    } wr_op_e;

    localparam logic [SEL_WIDTH:0]  REG_LIMIT = (SEL_WIDTH + 1)'(REG_COUNT);
    localparam logic [DATA_WIDTH:0] ONE       = (DATA_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    wr_op_e                op;
    logic                  dest_ok;
    logic                  a_ok;
    logic                  b_ok;
    logic                  op_write;
    logic                  wr_en;
    logic                  sel_bad;
    logic                  wr_carry;
    logic [DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0] wr_result;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    assign op      = wr_op_e'(bus.wr_op);
    assign dest_ok = {1'b0, bus.dest_sel}  < REG_LIMIT;
    assign a_ok    = {1'b0, bus.src_a_sel} < REG_LIMIT;
    assign b_ok    = {1'b0, bus.src_b_sel} < REG_LIMIT;
    assign wr_en   = op_write & dest_ok;
    assign sel_bad = op_write & ~dest_ok;

    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        cur = '0;
        if (dest_ok) cur = regs[bus.dest_sel];
    end

    // Carry/borrow falls out of the extra top bit of the widened add/subtract.
    always_comb begin
        op_write  = 1'b1;
        wr_result = cur;
        wr_carry  = 1'b0;
        case (op)
            OP_LOAD: wr_result = bus.wr_data;
            OP_INC:  {wr_carry, wr_result} = {1'b0, cur} + ONE;
            OP_DEC:  {wr_carry, wr_result} = {1'b0, cur} - ONE;
            OP_CLR:  wr_result = '0;
            default: op_write = 1'b0;
        endcase
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (a_ok) rd_a = regs[bus.src_a_sel];
        if (b_ok) rd_b = regs[bus.src_b_sel];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && bus.src_a_sel == bus.dest_sel) rd_a = wr_result;
        if (wr_en && bus.src_b_sel == bus.dest_sel) rd_b = wr_result;
`endif
    end

    // NOTE: the register array is reset explicitly because software relies on a known RESET_VALUE;
    // sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= RESET_VALUE;
            bus.src_a      <= '0;
            bus.src_b      <= '0;
            bus.zero_flag  <= 1'b0;
            bus.carry_flag <= 1'b0;
            bus.sel_err    <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[bus.dest_sel] <= wr_result;
                bus.zero_flag      <= (wr_result == '0);
                bus.carry_flag     <= wr_carry;
            end
            bus.sel_err <= sel_bad;
            bus.src_a   <= rd_a;
            bus.src_b   <= rd_b;
        end
    end
endmodule
